hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline interlock controller for the 6-stage core. Forwarding covers ALU results.
//  This block adds the stalls forwarding cannot cover:
//  - load-use stalls, because load data is only forwardable from WB;
//  - sequencing of the multi-cycle divider, holding ID until the quotient or remainder is ready.
//  It sits beside the forwarding unit and drives ID stall/flush and the divider start/cancel.
// PARAMETERS
//  DIV_TMO  64  max cycles in WAIT before div_err is raised and the FSM aborts to IDLE
// PORTS
//  clk         in   1  core clock
//  resetn      in   1  asynchronous reset, active-low
//  id_valid    in   1  ID holds a valid instruction
//  id_rj       in   5  ID source register rj
//  id_rkd      in   5  ID source register rk/rd
//  id_use_rj   in   1  ID reads rj
//  id_use_rkd  in   1  ID reads rk/rd
//  id_is_div   in   1  ID instruction is div/mod (w/wu)
//  ex_valid    in   1  EX valid
//  ex_is_load  in   1  EX holds a load
//  ex_dest     in   5  EX destination register
//  mem_valid   in   1  MEM valid
//  mem_is_load in   1  MEM holds a load
//  mem_dest    in   5  MEM destination register
//  br_flush    in   1  branch/exception redirect; kills ID and younger stages
//  div_done    in   1  divider result valid (1-cycle pulse)
//  id_stall    out  1  hold PC/IF/ID, insert bubble into EX
//  div_start   out  1  1-cycle pulse; launches divider on the ID operands
//  div_cancel  out  1  1-cycle pulse; aborts in-flight divide
//  div_busy    out  1  FSM not IDLE
//  div_err     out  1  sticky; timeout occurred, cleared only by reset
//  stall_cnt   out  16 saturating count of cycles with id_stall=1
// BEHAVIOUR
//  Reset (resetn=0, async): FSM=IDLE, all outputs 0, stall_cnt=0.
//  Load-use (combinational):
//   - hit_ex  = ex_valid & ex_is_load & ex_dest!=0 & ((id_use_rj & ex_dest==id_rj) | (id_use_rkd & ex_dest==id_rkd))
//   - hit_mem is the same check using the mem_* inputs
//   - lu_stall = id_valid & (hit_ex | hit_mem)
//   - Register r0 never stalls. A stage with valid=0 never stalls.
//  Divider FSM states: IDLE, START, WAIT, DONE.
//   - IDLE->START: id_valid & id_is_div & !lu_stall & !br_flush. div_start=1 in the START cycle only.
//   - START->WAIT: unconditional. A div_done in the START cycle is ignored (protocol violation).
//   - WAIT->DONE: on div_done.
//   - WAIT->IDLE on cycle counter == DIV_TMO-1: div_err<=1, div_cancel pulse.
//   - DONE->IDLE: unconditional. The result is captured by ID/EX in this cycle.
//  id_stall = lu_stall | (state==START) | (state==WAIT) | (state==IDLE & div launch condition).
//   - id_stall is 0 in DONE; the div advances to EX in that cycle.
//  br_flush in START or WAIT:
//   - next state = IDLE, div_cancel=1 for 1 cycle, id_stall=0 in the same cycle.
//   - A div_done coincident with br_flush is dropped; the flush wins.
//  br_flush in DONE: return to IDLE with no cancel.
//  br_flush in IDLE: suppresses launch.
//  Cycle counter: reset on entry to START, increments in WAIT, width clog2(DIV_TMO)+1.
//  stall_cnt: +1 per cycle with id_stall=1; saturates at 16'hFFFF with no wrap.
//  Reset mid-operation: returns to IDLE immediately, no div_cancel pulse. The divider is reset by the same resetn.
//  Latency: div_start appears 1 cycle after the launch condition. ID is released in the cycle after div_done.
// TESTING
//  1. EX lw r5, ID add r6,r5,r1 (use_rj): id_stall=1. Next cycle load in MEM: id_stall=1. Load in WB: id_stall=0.
//  2. EX load dest=0, ID reads r0 -> id_stall=0. EX load r7, ID id_use_rkd=0 with rkd=7 -> id_stall=0.
//  3. ID div.w, div_done 10 cycles after div_start:
//     - div_start pulse at cycle 1
//     - id_stall high cycles 0..11, low in DONE
//     - div_busy 0->1->0
//  4. ID div.w, br_flush asserted 3 cycles into WAIT: div_cancel=1 that cycle, FSM IDLE, id_stall=0, div_done later ignored.
//  5. DIV_TMO=8, div_done never asserted: div_err=1 and div_cancel pulse at WAIT cycle 8; div_err stays 1 until resetn=0.
//  6. resetn deasserted mid-WAIT -> all outputs 0 asynchronously. stall_cnt forced to 16'hFFFE plus 3 stall cycles -> reads 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM hazard inputs and divider handshake for the interlock controller
interface hazard_stall_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rj;
  logic [4:0] id_rkd;
  logic       id_use_rj;
  logic       id_use_rkd;
  logic       id_is_div;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_dest;
  logic       mem_valid;
  logic       mem_is_load;
  logic [4:0] mem_dest;
  logic       br_flush;
  logic       div_done;
  logic       id_stall;
  logic       div_start;
  logic       div_cancel;
  logic       div_busy;
  logic       div_err;
  logic [15:0] stall_cnt;
  modport slave (
    input  id_valid, id_rj, id_rkd, id_use_rj, id_use_rkd, id_is_div,
    input  ex_valid, ex_is_load, ex_dest, mem_valid, mem_is_load, mem_dest,
    input  br_flush, div_done,
    output id_stall, div_start, div_cancel, div_busy, div_err, stall_cnt
  );
  modport master (
    output id_valid, id_rj, id_rkd, id_use_rj, id_use_rkd, id_is_div,
    output ex_valid, ex_is_load, ex_dest, mem_valid, mem_is_load, mem_dest,
    output br_flush, div_done,
    input  id_stall, div_start, div_cancel, div_busy, div_err, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use interlock and multi-cycle divider sequencing for the ID stage
module hazard_stall_ctrl #(
  parameter int DIV_TMO = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  hazard_stall_ctrl_if.slave   bus
);
  localparam int CW = $clog2(DIV_TMO) + 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          hit_ex, hit_mem, lu_stall, launch, in_flight, timeout, stall;
  // Hazard detection, divider next state, timeout and stall counter
  always_comb begin
    hit_ex    = bus.ex_valid & bus.ex_is_load & (bus.ex_dest != 5'd0) &
                ((bus.id_use_rj & (bus.ex_dest == bus.id_rj)) | (bus.id_use_rkd & (bus.ex_dest == bus.id_rkd)));
    hit_mem   = bus.mem_valid & bus.mem_is_load & (bus.mem_dest != 5'd0) &
                ((bus.id_use_rj & (bus.mem_dest == bus.id_rj)) | (bus.id_use_rkd & (bus.mem_dest == bus.id_rkd)));
    lu_stall  = bus.id_valid & (hit_ex | hit_mem);
    in_flight = (state_q == START) | (state_q == WAIT);
    launch    = (state_q == IDLE) & bus.id_valid & bus.id_is_div & ~lu_stall & ~bus.br_flush;
    timeout   = (state_q == WAIT) & ~bus.br_flush & ~bus.div_done & (cyc_q == CW'(DIV_TMO - 1));
    stall     = lu_stall | (in_flight & ~bus.br_flush) | launch;
    state_d   = ((in_flight | (state_q == DONE)) & bus.br_flush) ? IDLE :
                launch             ? START :
                (state_q == START) ? WAIT :
                (state_q == WAIT)  ? (bus.div_done ? DONE : timeout ? IDLE : WAIT) :
                                     IDLE;
    cyc_d     = launch ? '0 : (state_q == WAIT) ? cyc_q + 1'b1 : cyc_q;
    err_d     = err_q | timeout;
    cnt_d     = (stall & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end
  // State, timeout counter, sticky error and stall counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Combinational outputs are masked while in reset so every output reads 0
  assign bus.id_stall   = resetn & stall;
  assign bus.div_cancel = resetn & ((in_flight & bus.br_flush) | timeout);
  assign bus.div_start  = (state_q == START);
  assign bus.div_busy   = (state_q != IDLE);
  assign bus.div_err    = err_q;
  assign bus.stall_cnt  = cnt_q;
endmodule
